fetch_ctrl: RTL and testbench

//   Instruction-fetch sequencer for the single-cycle CPU: owns the PC, drives the asynchronous

---
 rtl/fetch_ctrl_pkg.sv | 16 +
 rtl/fetch_pc_mux.sv | 28 ++
 rtl/fetch_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: control-state encoding
// and default geometry of the program ROM.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } ctrl_state_t;

    localparam int          ADDR_W_DEF    = 5;
    localparam int          ROM_DEPTH_DEF = 20;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_mux.sv
// Next-PC selection (jump over branch over sequential) and fetch legality of the
// current PC: word aligned and inside the populated part of the ROM.
module fetch_pc_mux
    import fetch_ctrl_pkg::*;
#(
    parameter int ROM_DEPTH = ROM_DEPTH_DEF
) (
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_target,
    output logic [31:0] next_pc,
    output logic        pc_legal
);

    always_comb begin
        next_pc = pc + 32'd4;
        if (jmp_taken) begin
            next_pc = jmp_target;
        end else if (br_taken) begin
            next_pc = br_target;
        end
    end

    assign pc_legal = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < 32'(ROM_DEPTH));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, shares the ROM address port with a
// debug reader, and provides halt / single-step / free-run control.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_HALT  | no fetches; debug reader owns the port whenever it asks
//   ST_STEP  | retire exactly one instruction, then back to ST_HALT
//   ST_RUN   | retire on every CPU-owned cycle until halt_req
//   ST_FAULT | illegal PC was fetched; left only through rst
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          ROM_DEPTH = ROM_DEPTH_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    input  logic              jmp_taken,
    input  logic [31:0]       jmp_target,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [31:0]       dbg_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    output logic [31:0]       pc,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic [1:0]        ctrl_state,
    output logic              pc_fault,
    output logic [31:0]       retire_cnt
);

    ctrl_state_t state;
    logic        dbg_last;
    logic [31:0] next_pc;
    logic        pc_legal;
    logic        cpu_active;
    logic        dbg_grant;
    logic        cpu_fetch;
    logic        fetch_fault;

    fetch_pc_mux #(
        .ROM_DEPTH (ROM_DEPTH)
    ) u_pc_mux (
        .pc         (pc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target),
        .next_pc    (next_pc),
        .pc_legal   (pc_legal)
    );

    // While fetching, a debug grant is never given twice in a row so the CPU
    // always gets at least every other cycle.
    assign cpu_active  = (state == ST_STEP) || (state == ST_RUN);
    assign dbg_grant   = dbg_req && !(cpu_active && dbg_last);
    assign cpu_fetch   = cpu_active && !dbg_grant;
    assign inst_valid  = cpu_fetch && pc_legal;
    assign fetch_fault = cpu_fetch && !pc_legal;

    assign rom_addr   = dbg_grant ? dbg_addr : pc[ADDR_W+1:2];
    assign dbg_ack    = dbg_grant;
    assign dbg_data   = dbg_grant ? rom_inst : 32'h0;
    assign inst       = dbg_grant ? 32'h0 : rom_inst;
    assign ctrl_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HALT;
            pc         <= RESET_PC;
            pc_fault   <= 1'b0;
            retire_cnt <= 32'h0;
            dbg_last   <= 1'b0;
        end else begin
            dbg_last <= dbg_grant;
            if (fetch_fault) begin
                pc_fault <= 1'b1;
            end
            if (inst_valid) begin
                pc         <= next_pc;
                retire_cnt <= retire_cnt + 32'd1;
            end
            case (state)
                ST_HALT: begin
                    if (run_req) begin
                        state <= ST_RUN;
                    end else if (step_req) begin
                        state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (fetch_fault) begin
                        state <= ST_FAULT;
                    end else if (inst_valid) begin
                        state <= ST_HALT;
                    end
                end
                ST_RUN: begin
                    if (fetch_fault) begin
                        state <= ST_FAULT;
                    end else if (halt_req) begin
                        state <= ST_HALT;
                    end
                end
                default: state <= ST_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: 20-word program ROM, directed scenarios then random
// stimulus, scoreboarded against a cycle-level behavioural model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0;
    logic        br_taken = 1'b0, jmp_taken = 1'b0;
    logic [31:0] br_target = 32'h0, jmp_target = 32'h0;
    logic        dbg_req = 1'b0;
    logic [4:0]  dbg_addr = 5'd0;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic [4:0]  rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] pc, inst, retire_cnt;
    logic        inst_valid, pc_fault;
    logic [1:0]  ctrl_state;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
        .br_taken(br_taken), .br_target(br_target), .jmp_taken(jmp_taken), .jmp_target(jmp_target),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
        .rom_addr(rom_addr), .rom_inst(rom_inst), .pc(pc), .inst(inst), .inst_valid(inst_valid),
        .ctrl_state(ctrl_state), .pc_fault(pc_fault), .retire_cnt(retire_cnt)
    );

    logic [31:0] rom [0:19];
    always_comb rom_inst = (rom_addr < 5'd20) ? rom[rom_addr] : 32'h0;

    typedef struct {
        bit          is_dbg;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;
    bit rst_seen = 0;

    // behavioural model: mode 0 halt, 1 step, 2 run, 3 fault
    int          m_mode = 0;
    logic [31:0] m_pc = 0, m_ret = 0, m_last_pc = 0;
    bit          m_fault = 0, m_prev = 0, m_last_valid = 0;

    bit          t_rst = 0, t_run = 0, t_step = 0, t_halt = 0, t_br = 0, t_jmp = 0, t_dbg = 0;
    logic [31:0] t_bt = 0, t_jt = 0;
    logic [4:0]  t_daddr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rand_target();
        int sel = $urandom_range(0, 19);
        if (sel == 0) return {25'h0, 5'($urandom_range(0, 19)), 2'b10};
        if (sel == 1) return {25'h0, 5'($urandom_range(20, 31)), 2'b00};
        return {25'h0, 5'($urandom_range(0, 19)), 2'b00};
    endfunction

    task automatic tick();
        bit busy, grant, fetch, legal, valid;
        exp_t e;
        @(negedge clk);
        if (rst_seen) mon_en = 1;
        rst = t_rst; run_req = t_run; step_req = t_step; halt_req = t_halt;
        br_taken = t_br; br_target = t_bt; jmp_taken = t_jmp; jmp_target = t_jt;
        dbg_req = t_dbg; dbg_addr = t_daddr;
        #1;
        if (mon_en) begin
            chk("ctrl_state", 32'(ctrl_state), 32'(m_mode));
            chk("pc", pc, m_pc);
            chk("pc_fault", 32'(pc_fault), 32'(m_fault));
            chk("retire_cnt", retire_cnt, m_ret);
        end
        busy  = (m_mode == 1) || (m_mode == 2);
        grant = t_dbg && !(busy && m_prev);
        fetch = busy && !grant;
        legal = (m_pc % 4 == 0) && (m_pc / 4 < 20);
        valid = fetch && legal;
        if (mon_en && grant) begin
            e.is_dbg = 1; e.data = (t_daddr < 5'd20) ? rom[t_daddr] : 32'h0; e.pc = 32'h0;
            exp_q.push_back(e);
        end
        if (mon_en && valid) begin
            e.is_dbg = 0; e.data = rom[int'(m_pc / 4)]; e.pc = m_pc;
            exp_q.push_back(e);
        end
        m_last_valid = valid;
        m_last_pc    = m_pc;
        if (t_rst) begin
            m_mode = 0; m_pc = 0; m_ret = 0; m_fault = 0; m_prev = 0;
            rst_seen = 1;
        end else begin
            m_prev = grant;
            if (fetch && !legal) begin
                m_fault = 1;
                m_mode  = 3;
            end else if (valid) begin
                m_ret = m_ret + 1;
                m_pc  = t_jmp ? t_jt : (t_br ? t_bt : m_pc + 4);
                if (m_mode == 1 || t_halt) m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = t_run ? 2 : (t_step ? 1 : 0);
            end else if (m_mode == 2 && t_halt) begin
                m_mode = 0;
            end
        end
    endtask

    // monitor: pops one expectation for every cycle the DUT presents a result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (inst_valid === 1'b1 || dbg_ack === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: actual inst_valid=%b dbg_ack=%b required none at %0t",
                                 inst_valid, dbg_ack, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dbg_ack", 32'(dbg_ack), 32'(e.is_dbg));
                        chk("inst_valid", 32'(inst_valid), 32'(!e.is_dbg));
                        if (e.is_dbg) begin
                            chk("dbg_data", dbg_data, e.data);
                            chk("inst_zero_on_dbg", inst, 32'h0);
                        end else begin
                            chk("inst", inst, e.data);
                            chk("fetch_pc", pc, e.pc);
                            chk("dbg_data_zero_on_cpu", dbg_data, 32'h0);
                        end
                    end
                end
                chk("missing_output", 32'(exp_q.size()), 32'h0);
                exp_q.delete();
            end
        end
    end

    initial begin
        logic [31:0] r0;
        for (int i = 0; i < 20; i++) rom[i] = 32'h2000_0000 + 32'(i * 32'h0101);
        rom[2]  = 32'h0041_1821;
        rom[5]  = 32'hAC25_0013;
        rom[11] = 32'h1121_0002;
        rom[19] = 32'h0800_0000;

        t_rst = 1; tick(); t_rst = 0;

        // free run with a branch at 0x2C and a jump back to 0 at 0x4C
        t_run = 1;
        for (int i = 0; i < 40; i++) begin
            t_br = (m_pc == 32'h2C); t_bt = 32'h34;
            t_jmp = (m_pc == 32'h4C); t_jt = 32'h0;
            tick();
            if (m_last_valid && m_last_pc == 32'h4C) break;
        end
        t_br = 0; t_jmp = 0;
        @(posedge clk); #1;
        chk("retire_at_jmp", retire_cnt, 32'd19);
        chk("pc_after_jmp", pc, 32'h0);

        t_run = 0; t_halt = 1; tick(); t_halt = 0; tick();
        chk("halted", 32'(ctrl_state), 32'd0);

        // debug reads while halted, then one step
        t_dbg = 1; t_daddr = 5'd5;
        repeat (3) tick();
        chk("dbg_word5", dbg_data, 32'hAC25_0013);
        r0 = m_ret;
        t_step = 1; tick(); t_step = 0;
        repeat (4) tick();
        chk("step_one_retire", retire_cnt, r0 + 32'd1);
        chk("step_back_halt", 32'(ctrl_state), 32'd0);

        // run with debug held: alternating ownership
        t_run = 1;
        repeat (12) tick();
        t_run = 0; t_dbg = 0; t_halt = 1; tick(); t_halt = 0; tick();

        // jump out of range -> fault, sticky against halt/run
        t_run = 1; t_jmp = 1; t_jt = 32'h50;
        repeat (2) tick();
        t_jmp = 0;
        repeat (2) tick();
        t_halt = 1;
        repeat (3) tick();
        t_halt = 0;
        chk("fault_state", 32'(ctrl_state), 32'd3);
        chk("fault_flag", 32'(pc_fault), 32'd1);
        chk("fault_pc", pc, 32'h50);
        t_run = 0; t_rst = 1; tick(); t_rst = 0; tick();
        chk("rst_clears_fault", 32'(ctrl_state), 32'd0);
        chk("rst_pc", pc, 32'h0);

        // reset in the middle of a run
        t_run = 1;
        repeat (6) tick();
        t_rst = 1; tick(); t_rst = 0; t_run = 0; tick();
        chk("midrun_rst_pc", pc, 32'h0);
        chk("midrun_rst_retire", retire_cnt, 32'h0);
        chk("midrun_rst_valid", 32'(inst_valid), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            t_rst   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) t_run = !t_run;
            t_step  = ($urandom_range(0, 5) == 0);
            t_halt  = ($urandom_range(0, 9) == 0);
            t_dbg   = ($urandom_range(0, 2) == 0);
            t_daddr = 5'($urandom_range(0, 31));
            t_br    = ($urandom_range(0, 4) == 0);
            t_bt    = rand_target();
            t_jmp   = ($urandom_range(0, 9) == 0);
            t_jt    = rand_target();
            tick();
        end
        t_rst = 0; t_run = 0; t_step = 0; t_halt = 0; t_dbg = 0; t_br = 0; t_jmp = 0;
        tick();
        @(negedge clk); #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
